btn_debounce_multi: RTL and testbench

//  Parametrised N-channel push-button conditioner replacing fixed 3-button 40 Hz edge detect.
//  Per channel: 2-FF synchroniser, tick-sampled stability filter, debounced level,

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_chan.sv | 166 ++++++++++++++++
 rtl/btn_debounce_multi.sv | 69 ++++++
 tb/tb_btn_debounce_multi.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } btn_state_e;

  // Width of a counter that must hold values 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: tick-sampled stability filter, hold FSM, pulse outputs.
module btn_chan
  import btn_pkg::*;
#(
  parameter int STABLE_N = 20,
  parameter int LONG_N   = 1000,
  parameter int REP_N    = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick_i,
  input  logic s_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int SCW = cnt_w(STABLE_N);
  localparam int HCW = cnt_w(LONG_N);
  localparam int RCW = cnt_w(REP_N);

  localparam logic [SCW-1:0] SC_LAST = SCW'(STABLE_N - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'((LONG_N > 0) ? LONG_N - 1 : 0);
  localparam logic [RCW-1:0] RC_LAST = RCW'((REP_N > 0) ? REP_N - 1 : 0);
  localparam bit LONG_EN = (LONG_N > 0);
  localparam bit REP_EN  = (REP_N > 0);

  btn_state_e state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [HCW-1:0] hc_q, hc_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic disagree;
  logic flip;

  assign disagree = (s_i != level_q);
  // The last of STABLE_N consecutive disagreeing ticks flips the level.
  assign flip = tick_i && disagree && (sc_q == SC_LAST);

  // Stability filter: any agreeing tick restarts the disagreement count.
  always_comb begin
    sc_d    = sc_q;
    level_d = level_q;
    if (tick_i) begin
      if (!disagree || flip) begin
        sc_d = '0;
      end else begin
        sc_d = sc_q + 1'b1;
      end
      if (flip) begin
        level_d = ~level_q;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a flip always wins over a long/repeat threshold on the same tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (flip) state_d = DOWN;
      DOWN: begin
        if (flip) begin
          state_d = IDLE;
        end else if (tick_i && LONG_EN && (hc_q == HC_LAST)) begin
          state_d = HELD;
        end
      end
      HELD: if (flip) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next values of the hold counters and the one-cycle pulses.
  always_comb begin
    hc_d      = hc_q;
    rc_d      = rc_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flip) begin
          press_d = 1'b1;
          hc_d    = '0;
          rc_d    = '0;
        end
      end
      DOWN: begin
        if (flip) begin
          release_d = 1'b1;
          hc_d      = '0;
          rc_d      = '0;
        end else if (tick_i && LONG_EN) begin
          if (hc_q == HC_LAST) begin
            long_d = 1'b1;
            hc_d   = '0;
            rc_d   = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (flip) begin
          release_d = 1'b1;
          hc_d      = '0;
          rc_d      = '0;
        end else if (tick_i && REP_EN) begin
          if (rc_q == RC_LAST) begin
            repeat_d = 1'b1;
            rc_d     = '0;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Counters, level and registered pulse outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sc_q      <= '0;
      hc_q      <= '0;
      rc_q      <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sc_q      <= sc_d;
      hc_q      <= hc_d;
      rc_q      <= rc_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: shared tick divider, input synchroniser,
// and one btn_chan per button.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int ACT_HIGH = 1,
  parameter int STABLE_N = 20,
  parameter int LONG_N   = 1000,
  parameter int REP_N    = 100
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] BIN,
  output logic [NCH-1:0] LEVEL,
  output logic [NCH-1:0] PRESS,
  output logic [NCH-1:0] RELEASE,
  output logic [NCH-1:0] LONG,
  output logic [NCH-1:0] REPEAT
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = cnt_w(DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  logic [TW-1:0]  cnt_q, cnt_d;
  logic           tick;
  logic [NCH-1:0] pin_pressed;
  logic [NCH-1:0] s1_q, s2_q;

  assign tick        = (cnt_q == TICK_LAST);
  assign cnt_d       = tick ? '0 : cnt_q + 1'b1;
  // Normalise polarity so 1 always means pressed from here on.
  assign pin_pressed = (ACT_HIGH != 0) ? BIN : ~BIN;

  // Tick divider and two-flop synchroniser; both start in the released state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      s1_q  <= pin_pressed;
      s2_q  <= s1_q;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    btn_chan #(
      .STABLE_N (STABLE_N),
      .LONG_N   (LONG_N),
      .REP_N    (REP_N)
    ) u_chan (
      .CLK       (CLK),
      .RST       (RST),
      .tick_i    (tick),
      .s_i       (s2_q[g]),
      .level_o   (LEVEL[g]),
      .press_o   (PRESS[g]),
      .release_o (RELEASE[g]),
      .long_o    (LONG[g]),
      .repeat_o  (REPEAT[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: an active-high and an active-low instance
// driven with complementary pins, both checked every cycle against a
// behavioural model, plus hand-computed timing points.
module tb_btn_debounce_multi;

  localparam int NCH      = 3;
  localparam int CLK_HZ   = 16;
  localparam int TICK_HZ  = 4;
  localparam int STABLE_N = 3;
  localparam int LONG_N   = 5;
  localparam int REP_N    = 2;
  localparam int DIV      = CLK_HZ / TICK_HZ;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [NCH-1:0] bin = '0;
  logic [NCH-1:0] bin_n;
  logic [NCH-1:0] lv_p, pr_p, rl_p, lg_p, rp_p;
  logic [NCH-1:0] lv_n, pr_n, rl_n, lg_n, rp_n;

  assign bin_n = ~bin;

  btn_debounce_multi #(
    .NCH(NCH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ACT_HIGH(1),
    .STABLE_N(STABLE_N), .LONG_N(LONG_N), .REP_N(REP_N)
  ) dut_p (
    .CLK(CLK), .RST(RST), .BIN(bin),
    .LEVEL(lv_p), .PRESS(pr_p), .RELEASE(rl_p), .LONG(lg_p), .REPEAT(rp_p)
  );

  btn_debounce_multi #(
    .NCH(NCH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ACT_HIGH(0),
    .STABLE_N(STABLE_N), .LONG_N(LONG_N), .REP_N(REP_N)
  ) dut_n (
    .CLK(CLK), .RST(RST), .BIN(bin_n),
    .LEVEL(lv_n), .PRESS(pr_n), .RELEASE(rl_n), .LONG(lg_n), .REPEAT(rp_n)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n counts clock edges since RST was last released; every DIV-th edge is a
  // tick edge. The value filtered at edge n is the pin seen two edges earlier.
  bit             started = 1'b0;
  int             n = 0;
  logic [NCH-1:0] h1 = '0, h2 = '0;
  logic [NCH-1:0] m_lvl = '0;
  logic [NCH-1:0] e_pr = '0, e_rl = '0, e_lg = '0, e_rp = '0;
  int             run  [NCH];
  int             held [NCH];

  always @(negedge CLK) begin
    if (started) begin
      chk("model_act_high", {lv_p, pr_p, rl_p, lg_p, rp_p}, {m_lvl, e_pr, e_rl, e_lg, e_rp});
      chk("model_act_low",  {lv_n, pr_n, rl_n, lg_n, rp_n}, {m_lvl, e_pr, e_rl, e_lg, e_rp});
    end
    e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
    if (RST) begin
      started = 1'b1;
      n = 0; h1 = '0; h2 = '0; m_lvl = '0;
      for (int c = 0; c < NCH; c++) begin run[c] = 0; held[c] = 0; end
    end else begin
      n++;
      if (n % DIV == 0) begin
        for (int c = 0; c < NCH; c++) begin
          bit flipped;
          flipped = 1'b0;
          if (h2[c] != m_lvl[c]) begin
            run[c]++;
            if (run[c] == STABLE_N) begin
              flipped  = 1'b1;
              run[c]   = 0;
              held[c]  = 0;
              m_lvl[c] = ~m_lvl[c];
              if (m_lvl[c]) e_pr[c] = 1'b1;
              else          e_rl[c] = 1'b1;
            end
          end else begin
            run[c] = 0;
          end
          if (!flipped && m_lvl[c]) begin
            held[c]++;
            if (LONG_N > 0 && held[c] == LONG_N) e_lg[c] = 1'b1;
            if (LONG_N > 0 && REP_N > 0 && held[c] > LONG_N &&
                ((held[c] - LONG_N) % REP_N) == 0) e_rp[c] = 1'b1;
          end
        end
      end
      h2 = h1;
      h1 = bin;
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    bit bounce_seen;
    int fast;
    bounce_seen = 1'b0;
    RST = 1'b1;
    bin = '0;
    step(10);
    chk("reset_outputs", {lv_p, pr_p, rl_p, lg_p, rp_p}, 15'd0);
    RST = 1'b0;
    bin = 3'b001;

    // cyc = number of edges since RST released
    for (int cyc = 1; cyc <= 130; cyc++) begin
      step(1);
      case (cyc)
        11:  chk("press0_early",   {9'd0, lv_p, pr_p}, 15'd0);
        12:  chk("press0",         {9'd0, lv_p, pr_p}, {9'd0, 3'b001, 3'b001});
        13:  chk("press0_1clk",    {9'd0, lv_p, pr_p}, {9'd0, 3'b001, 3'b000});
        31:  chk("long0_early",    {12'd0, lg_p}, 15'd0);
        32:  chk("long0",          {9'd0, lg_p, rp_p}, {9'd0, 3'b001, 3'b000});
        40:  chk("repeat0_a",      {9'd0, lg_p, rp_p}, {9'd0, 3'b000, 3'b001});
        44:  chk("repeat0_gap",    {12'd0, rp_p}, 15'd0);
        48:  chk("repeat0_b",      {12'd0, rp_p}, {12'd0, 3'b001});
        71:  chk("release0_early", {6'd0, lv_p, rl_p, rp_p}, {6'd0, 3'b001, 3'b000, 3'b000});
        72:  chk("release0_only",  {6'd0, lv_p, rl_p, rp_p}, {6'd0, 3'b000, 3'b001, 3'b000});
        91:  chk("press101_early", {12'd0, pr_p}, 15'd0);
        92:  chk("press101",       {3'd0, lv_p, pr_p, lv_n, pr_n},
                                   {3'd0, 3'b101, 3'b101, 3'b101, 3'b101});
        112: chk("long101",        {12'd0, lg_p}, {12'd0, 3'b101});
        114: chk("rst_mid_held",   {lv_p, pr_p, rl_p, lg_p, rp_p}, 15'd0);
        115: chk("rst_no_release", {lv_n, pr_n, rl_n, lg_n, rp_n}, 15'd0);
        126: chk("repress_early",  {9'd0, lv_p, pr_p}, 15'd0);
        127: chk("repress",        {9'd0, lv_p, pr_p}, {9'd0, 3'b101, 3'b101});
        default: ;
      endcase
      if (cyc <= 72 && (lv_p[1] || pr_p[1])) bounce_seen = 1'b1;
      if (cyc >= 13 && cyc <= 57 && (cyc % 4) == 1) bin[1] = ~bin[1];
      if (cyc == 60)  bin = 3'b000;
      if (cyc == 80)  bin = 3'b101;
      if (cyc == 113) RST = 1'b1;
      if (cyc == 115) RST = 1'b0;
    end
    chk("bounce_rejected", {14'd0, bounce_seen}, 15'd0);

    // Randomised phase: alternating bouncy and calm stretches, rare resets.
    fast = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ((i % 400) == 0) fast = ($urandom_range(0, 2) == 0) ? 1 : 0;
      RST = ($urandom_range(0, 899) == 0);
      if ($urandom_range(0, fast ? 3 : 39) == 0) begin
        int j;
        j = $urandom_range(0, NCH - 1);
        bin[j] = ~bin[j];
      end
    end
    RST = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
